z80_mmu_gen: RTL and testbench
==============================

Name: z80_mmu_gen

Overview:
Parametrised next-generation Z80 memory/IO controller for the mintz80 board. It is a drop-in successor to the current 8-page MMU: per-page bank registers, ROM/RAM steering, clock divider and beeper. All register state is now synchronous to clk; CPU strobes are synchronised into that domain. New features: per-page write protection with a sticky fault flag, a keyed lock over configuration registers, and full 8-bit readback.

Parameters:
PAGE_BITS, 3, log2 of page count; page size is 64K >> PAGE_BITS; legal range 1..3.
BANK_W, 6, page-entry width; bit0 is 1=RAM/0=ROM, bits BANK_W-1:1 are the bank number; range 2..8.
DIV_W, 2, width of the sysclk divider register; range 1..4.
IO_BASE, 8'hD0, base of the 16-port IO window; low nibble must be 0.
UNLOCK_KEY, 8'hA5, value written to LOCK that clears the lock.

Ports:
clk  in  1  fast oscillator; every register is clocked on its rising edge.
reset  in  1  asynchronous, active-low.
sysclk  out  1  divided CPU clock.
iorq_n, mreq_n, rd_n, wr_n  in  1 each  Z80 strobes, active-low, asynchronous to clk.
a_lo  in  8  A7..A0.
a_hi  in  PAGE_BITS  top address bits; selects the page.
din  in  8  CPU data bus in.
dout  out  8  readback data.
doe  out  1  dout enable; the top level tristates the bus with it.
romen_n, ramen_n  out  1 each  memory chip enables.
bank  out  BANK_W-1  bank number for the current page.
extio_n  out  1  external IO select, ports IO_BASE+4..+7.
beep  out  1  beeper toggle output.
wp_fault  out  1  sticky write-protect violation flag.

Behaviour:
- Reset values:
  - page[0] = 0 (ROM bank 0); page[1..N-1] = 1 (RAM bank 0).
  - clkdiv = 1; wp = 0; lock = 0; fault = 0; beep = 0; sysclk = 0; divider counter = 0.
  - Synchroniser flops reset to 1 (inactive).
- Register map, offset from IO_BASE:
  - +0 CLKDIV: read/write, low DIV_W bits.
  - +1 BEEP: a write toggles beep; a read returns {7'b0,beep}.
  - +2 WP: read/write, bit i protects page i; upper bits read 0.
  - +3 LOCK: a write clears fault; the lock bit is cleared if the value equals UNLOCK_KEY, otherwise set. A read returns {6'b0,fault,lock}.
  - +4..+7: extio_n=0, combinational on iorq_n=0 and address match. No internal register.
  - +8..+F PAGE: entry index a_lo[PAGE_BITS-1:0]; writes with index >= 2^PAGE_BITS alias.
- Readback:
  - Combinational: doe = !iorq_n & !rd_n & window hit & offset not in +4..+7.
  - dout carries the zero-extended register value; dout = 0 when doe = 0.
- Write commit:
  - iorq_n and wr_n each pass through 2-FF synchronisers.
  - A commit strobe fires for one clk on the synchronised falling edge of (iorq & wr).
  - a_lo and din are sampled directly on that cycle; the Z80 holds them stable through the IO write.
  - Latency: 2–3 clk from the wr_n fall to the register update.
  - Exactly one commit per strobe regardless of strobe length.
- Lock:
  - While lock = 1, commits to CLKDIV, WP and PAGE are ignored.
  - BEEP and LOCK writes always take effect.
- Memory decode (combinational; no clk latency on the address path):
  - e = page[a_hi].
  - romen_n = mreq_n | e[0] | blk.
  - ramen_n = mreq_n | ~e[0] | blk.
  - bank = e[BANK_W-1:1].
  - blk = wp[a_hi] & !wr_n & !mreq_n.
  - A protected write therefore asserts neither enable. Protected reads are unaffected.
- Fault:
  - Set on the synchronised falling edge of (mreq & wr & wp[a_hi]).
  - Cleared by a LOCK write.
  - Set wins if both happen in the same clk.
  - wp_fault = fault.
- Clock divider:
  - Counter width DIV_W.
  - When cnt == clkdiv: sysclk toggles and cnt clears; otherwise cnt increments.
  - sysclk period = 2*(clkdiv+1) clk.
  - A new clkdiv applies from the next compare. If cnt > new clkdiv, the counter wraps through 2^DIV_W before matching; no glitch shorter than one clk.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - A pending commit is dropped.
  - sysclk is forced low.

Test Plan:
1. Reset -> page0 access asserts romen_n=0 with bank=0; page5 access asserts ramen_n=0 with bank=0; sysclk period 4 clk; doe=0; beep=0; wp_fault=0.
2. IO write 8'h0B to $DD, then IO read $DD with PAGE_BITS=3, BANK_W=6 -> dout=8'h0B, doe=1; an mreq read at 0xA000 asserts ramen_n=0 with bank=5; commit lands 2–3 clk after wr_n falls.
3. Write 8'h00 to $D3, then 8'h07 to $DA -> page2 unchanged. Then write 8'hA5 to $D3 and 8'h07 to $DA -> page2 = 7. Read $D3 -> dout=8'h00.
4. Write 8'h04 to $D2; mreq write to 0x4000 -> both enables stay high; wp_fault=1; $D3 reads 8'h02. An mreq read of 0x4000 -> ramen_n=0. Write 8'hA5 to $D3 -> wp_fault=0.
5. Write 3 to $D0 mid-period -> sysclk period becomes 8 clk with no pulse shorter than 1 clk. Two writes to $D1 -> beep toggles twice and returns to 0.
6. Assert reset during a $D8 write strobe -> registers hold reset values after release and the strobe does not commit. An IO read of $D5 -> extio_n=0, doe=0.

Source files
------------

// File: rtl/z80_mmu_gen.sv
// z80_mmu_gen: Z80 memory/IO controller for the mintz80 board. It provides page banking,
// ROM/RAM steering, per-page write protection, a keyed config lock, the sysclk divider and a beeper.
module z80_mmu_gen #(
  parameter int          PAGE_BITS  = 3,
  parameter int          BANK_W     = 6,
  parameter int          DIV_W      = 2,
  parameter logic [7:0]  IO_BASE    = 8'hD0,
  parameter logic [7:0]  UNLOCK_KEY = 8'hA5
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 sysclk,
  input  logic                 iorq_n,
  input  logic                 mreq_n,
  input  logic                 rd_n,
  input  logic                 wr_n,
  input  logic [7:0]           a_lo,
  input  logic [PAGE_BITS-1:0] a_hi,
  input  logic [7:0]           din,
  output logic [7:0]           dout,
  output logic                 doe,
  output logic                 romen_n,
  output logic                 ramen_n,
  output logic [BANK_W-2:0]    bank,
  output logic                 extio_n,
  output logic                 beep,
  output logic                 wp_fault
);

  localparam int NPAGES = 1 << PAGE_BITS;

  logic iorq_s1_q, iorq_s2_q, wr_s1_q, wr_s2_q, mreq_s1_q, mreq_s2_q;
  logic io_wr_prev_q, mem_wp_prev_q;
  logic io_wr_lvl, mem_wp_lvl, commit, fault_set;

  logic [BANK_W-1:0] page_q [NPAGES];
  logic [BANK_W-1:0] page_d [NPAGES];
  logic [DIV_W-1:0]  clkdiv_q, clkdiv_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [NPAGES-1:0] wp_q, wp_d;
  logic              lock_q, lock_d;
  logic              fault_q, fault_d;
  logic              beep_q, beep_d;
  logic              sysclk_q, sysclk_d;

  logic              hit, is_ext;
  logic [3:0]        off;
  logic [7:0]        rd_val;
  logic [BANK_W-1:0] entry;
  logic              blk;

  assign off    = a_lo[3:0];
  assign hit    = (a_lo[7:4] == IO_BASE[7:4]);
  assign is_ext = (off[3:2] == 2'b01);

  // Strobes are level-synchronised; commits come from the synchronised falling edge only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iorq_s1_q     <= 1'b1;
      iorq_s2_q     <= 1'b1;
      wr_s1_q       <= 1'b1;
      wr_s2_q       <= 1'b1;
      mreq_s1_q     <= 1'b1;
      mreq_s2_q     <= 1'b1;
      io_wr_prev_q  <= 1'b0;
      mem_wp_prev_q <= 1'b0;
    end else begin
      iorq_s1_q     <= iorq_n;
      iorq_s2_q     <= iorq_s1_q;
      wr_s1_q       <= wr_n;
      wr_s2_q       <= wr_s1_q;
      mreq_s1_q     <= mreq_n;
      mreq_s2_q     <= mreq_s1_q;
      io_wr_prev_q  <= io_wr_lvl;
      mem_wp_prev_q <= mem_wp_lvl;
    end
  end

  assign io_wr_lvl  = ~iorq_s2_q & ~wr_s2_q;
  assign commit     = io_wr_lvl & ~io_wr_prev_q;
  assign mem_wp_lvl = ~mreq_s2_q & ~wr_s2_q & wp_q[a_hi];
  assign fault_set  = mem_wp_lvl & ~mem_wp_prev_q;

  always_comb begin
    page_d   = page_q;
    clkdiv_d = clkdiv_q;
    wp_d     = wp_q;
    lock_d   = lock_q;
    beep_d   = beep_q;
    fault_d  = fault_q;
    if (commit && hit) begin
      if (off[3]) begin
        if (!lock_q) page_d[a_lo[PAGE_BITS-1:0]] = din[BANK_W-1:0];
      end else begin
        case (off[2:0])
          3'd0: if (!lock_q) clkdiv_d = din[DIV_W-1:0];
          3'd1: beep_d = ~beep_q;
          3'd2: if (!lock_q) wp_d = din[NPAGES-1:0];
          3'd3: begin
            fault_d = 1'b0;
            lock_d  = (din != UNLOCK_KEY);
          end
          default: ;
        endcase
      end
    end
    // A violation in the same cycle as a LOCK write still leaves the flag set.
    if (fault_set) fault_d = 1'b1;
  end

  always_comb begin
    sysclk_d = sysclk_q;
    cnt_d    = cnt_q + DIV_W'(1);
    if (cnt_q == clkdiv_q) begin
      sysclk_d = ~sysclk_q;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NPAGES; i++)
        page_q[i] <= (i == 0) ? '0 : BANK_W'(1);
      clkdiv_q <= DIV_W'(1);
      cnt_q    <= '0;
      wp_q     <= '0;
      lock_q   <= 1'b0;
      fault_q  <= 1'b0;
      beep_q   <= 1'b0;
      sysclk_q <= 1'b0;
    end else begin
      page_q   <= page_d;
      clkdiv_q <= clkdiv_d;
      cnt_q    <= cnt_d;
      wp_q     <= wp_d;
      lock_q   <= lock_d;
      fault_q  <= fault_d;
      beep_q   <= beep_d;
      sysclk_q <= sysclk_d;
    end
  end

  always_comb begin
    rd_val = '0;
    if (off[3]) begin
      rd_val[BANK_W-1:0] = page_q[a_lo[PAGE_BITS-1:0]];
    end else begin
      case (off[2:0])
        3'd0:    rd_val[DIV_W-1:0]  = clkdiv_q;
        3'd1:    rd_val[0]          = beep_q;
        3'd2:    rd_val[NPAGES-1:0] = wp_q;
        3'd3:    rd_val[1:0]        = {fault_q, lock_q};
        default: ;
      endcase
    end
  end

  assign doe     = ~iorq_n & ~rd_n & hit & ~is_ext;
  assign dout    = doe ? rd_val : '0;
  assign extio_n = ~(~iorq_n & hit & is_ext);

  assign entry   = page_q[a_hi];
  assign blk     = wp_q[a_hi] & ~wr_n & ~mreq_n;
  assign romen_n = mreq_n | entry[0] | blk;
  assign ramen_n = mreq_n | ~entry[0] | blk;
  assign bank    = entry[BANK_W-1:1];

  assign sysclk   = sysclk_q;
  assign beep     = beep_q;
  assign wp_fault = fault_q;

endmodule

// File: tb/tb_z80_mmu_gen.sv
// Directed bench for z80_mmu_gen: expected values are queued as stimulus is applied and
// popped when the matching DUT output is sampled.
module tb_z80_mmu_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       sysclk;
  logic       iorq_n, mreq_n, rd_n, wr_n;
  logic [7:0] a_lo;
  logic [2:0] a_hi;
  logic [7:0] din;
  logic [7:0] dout;
  logic       doe, romen_n, ramen_n, extio_n, beep, wp_fault;
  logic [4:0] bank;

  z80_mmu_gen #(
    .PAGE_BITS (3),
    .BANK_W    (6),
    .DIV_W     (2),
    .IO_BASE   (8'hD0),
    .UNLOCK_KEY(8'hA5)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sysclk  (sysclk),
    .iorq_n  (iorq_n),
    .mreq_n  (mreq_n),
    .rd_n    (rd_n),
    .wr_n    (wr_n),
    .a_lo    (a_lo),
    .a_hi    (a_hi),
    .din     (din),
    .dout    (dout),
    .doe     (doe),
    .romen_n (romen_n),
    .ramen_n (ramen_n),
    .bank    (bank),
    .extio_n (extio_n),
    .beep    (beep),
    .wp_fault(wp_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      $error("FAIL sb_empty: observed %h required an expectation", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) passed++;
      else $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
    end
  endtask

  task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
    @(negedge clk);
    a_lo = addr; din = data; iorq_n = 1'b0; wr_n = 1'b0;
    repeat (4) @(negedge clk);
    wr_n = 1'b1; iorq_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic io_read(input logic [7:0] addr, output logic [7:0] d,
                         output logic oe, output logic ext);
    @(negedge clk);
    a_lo = addr; iorq_n = 1'b0; rd_n = 1'b0;
    #1;
    d = dout; oe = doe; ext = extio_n;
    @(negedge clk);
    iorq_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic mem_rd(input logic [2:0] pg, output logic rom, output logic ram,
                        output logic [4:0] bk);
    @(negedge clk);
    a_hi = pg; mreq_n = 1'b0; rd_n = 1'b0;
    #1;
    rom = romen_n; ram = ramen_n; bk = bank;
    @(negedge clk);
    mreq_n = 1'b1; rd_n = 1'b1;
  endtask

  // Period in clk cycles between sysclk rising edges, plus the shortest half seen; -1 on timeout.
  task automatic measure(output int period, output int minhalf);
    logic prev, last;
    bit   found;
    int   n, hl;
    period = -1; minhalf = 99; found = 0;
    @(negedge clk);
    prev = sysclk;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!prev && sysclk) begin found = 1; break; end
      prev = sysclk;
    end
    if (found) begin
      last = 1'b1; hl = 1; n = 0;
      for (int i = 0; i < 64; i++) begin
        @(negedge clk);
        n++;
        if (sysclk == last) hl++;
        else begin
          if (hl < minhalf) minhalf = hl;
          hl = 1; last = sysclk;
          if (sysclk) begin period = n; break; end
        end
      end
    end
  endtask

  bit   mon_en = 0, mon_started;
  logic mon_last;
  int   mon_run, mon_min;
  always @(negedge clk) begin
    if (mon_en) begin
      if (sysclk == mon_last) mon_run++;
      else begin
        if (mon_started && mon_run < mon_min) mon_min = mon_run;
        mon_started = 1; mon_run = 1; mon_last = sysclk;
      end
    end
  end

  initial begin
    logic [7:0] d;
    logic       oe, ext, rom, ram;
    logic [4:0] bk;
    int         per, mh, lat;

    reset = 1'b0; iorq_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    a_lo = '0; a_hi = '0; din = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Reset state
    push("rst_doe", 0);      check(doe);
    push("rst_dout", 0);     check(dout);
    push("rst_beep", 0);     check(beep);
    push("rst_fault", 0);    check(wp_fault);
    mem_rd(3'd0, rom, ram, bk);
    push("p0_romen", 0);     check(rom);
    push("p0_ramen", 1);     check(ram);
    push("p0_bank", 0);      check(bk);
    mem_rd(3'd5, rom, ram, bk);
    push("p5_ramen", 0);     check(ram);
    push("p5_romen", 1);     check(rom);
    push("p5_bank", 0);      check(bk);
    measure(per, mh);
    push("rst_period", 4);   check(per);

    // Page write with commit latency, strobe held long to show a single commit
    a_hi = 3'd5;
    @(negedge clk);
    a_lo = 8'hDD; din = 8'h0B; iorq_n = 1'b0; wr_n = 1'b0;
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      if (bank == 5'd5 && lat < 0) lat = i;
    end
    push("commit_edges", 3); check(lat);
    @(negedge clk);
    wr_n = 1'b1; iorq_n = 1'b1;
    repeat (2) @(negedge clk);
    io_read(8'hDD, d, oe, ext);
    push("rd_DD", 8'h0B);    check(d);
    push("rd_DD_doe", 1);    check(oe);
    mem_rd(3'd5, rom, ram, bk);
    push("A000_ramen", 0);   check(ram);
    push("A000_bank", 5);    check(bk);

    // Lock blocks page writes until the key is written
    io_write(8'hD3, 8'h00);
    io_read(8'hD3, d, oe, ext);
    push("rd_D3_locked", 8'h01); check(d);
    io_write(8'hDA, 8'h07);
    mem_rd(3'd2, rom, ram, bk);
    push("p2_locked_bank", 0);   check(bk);
    io_write(8'hD3, 8'hA5);
    io_write(8'hDA, 8'h07);
    mem_rd(3'd2, rom, ram, bk);
    push("p2_bank", 3);          check(bk);
    push("p2_ramen", 0);         check(ram);
    io_read(8'hDA, d, oe, ext);
    push("rd_DA", 8'h07);        check(d);
    io_read(8'hD3, d, oe, ext);
    push("rd_D3_unlocked", 8'h00); check(d);

    // Write protection and sticky fault
    io_write(8'hD2, 8'h04);
    io_read(8'hD2, d, oe, ext);
    push("rd_D2", 8'h04);        check(d);
    @(negedge clk);
    a_hi = 3'd5; mreq_n = 1'b0; wr_n = 1'b0;
    #1;
    push("unprot_wr_ramen", 0);  check(ramen_n);
    repeat (5) @(negedge clk);
    mreq_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(negedge clk);
    push("unprot_no_fault", 0);  check(wp_fault);
    a_hi = 3'd2; mreq_n = 1'b0; wr_n = 1'b0;
    #1;
    push("prot_wr_romen", 1);    check(romen_n);
    push("prot_wr_ramen", 1);    check(ramen_n);
    repeat (5) @(negedge clk);
    mreq_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(negedge clk);
    push("fault_set", 1);        check(wp_fault);
    io_read(8'hD3, d, oe, ext);
    push("rd_D3_fault", 8'h02);  check(d);
    mem_rd(3'd2, rom, ram, bk);
    push("prot_rd_ramen", 0);    check(ram);
    io_write(8'hD3, 8'hA5);
    push("fault_clr", 0);        check(wp_fault);

    // Clock divider change and beeper
    @(posedge clk);
    mon_min = 99; mon_started = 0; mon_run = 0; mon_last = sysclk; mon_en = 1;
    io_write(8'hD0, 8'h03);
    measure(per, mh);
    measure(per, mh);
    mon_en = 0;
    push("div3_period", 8);      check(per);
    push("div3_half", 4);        check(mh);
    push("no_short_pulse", 1);   check((mon_min >= 2 && mon_min < 99) ? 1 : 0);
    io_read(8'hD0, d, oe, ext);
    push("rd_D0", 8'h03);        check(d);
    io_write(8'hD1, 8'h00);
    push("beep_1", 1);           check(beep);
    io_read(8'hD1, d, oe, ext);
    push("rd_D1", 8'h01);        check(d);
    io_write(8'hD1, 8'h00);
    push("beep_0", 0);           check(beep);

    // Reset during an in-flight page-0 write
    @(negedge clk);
    a_lo = 8'hD8; din = 8'h0E; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    push("rst_sysclk_low", 0);   check(sysclk);
    repeat (2) @(negedge clk);
    iorq_n = 1'b1; wr_n = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    mem_rd(3'd0, rom, ram, bk);
    push("p0_after_rst_romen", 0); check(rom);
    push("p0_after_rst_bank", 0);  check(bk);
    io_read(8'hD0, d, oe, ext);
    push("rd_D0_rst", 8'h01);    check(d);
    io_read(8'hD2, d, oe, ext);
    push("rd_D2_rst", 8'h00);    check(d);
    measure(per, mh);
    push("rst2_period", 4);      check(per);
    io_read(8'hD5, d, oe, ext);
    push("D5_extio", 0);         check(ext);
    push("D5_doe", 0);           check(oe);
    push("D5_dout", 0);          check(d);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
